// File: rtl/led_switch_io.sv
`default_nettype none
// ============================================================================
// Module   : led_switch_io
// Brief    : 24-LED output register and 24-switch debounced input port,
//            read/written as 16-bit half-words behind the IO decoder.
// Revision : 1.0  initial release
// ============================================================================
module led_switch_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioRead,
  input  logic        ioWrite,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [1:0]  addr_low,
  input  logic [15:0] write_data,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic [15:0] io_rdata
);

  localparam int unsigned      CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [23:0]   sync1;
  logic [23:0]   sync2;
  logic [23:0]   candidate;
  logic [23:0]   sw_db;
  logic [CW-1:0] cnt;

  // Only half-word granularity is decoded; the byte-select bit has no role.
  logic unused_addr_bit0;
  assign unused_addr_bit0 = addr_low[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (ioWrite && LEDCtrl) begin
      if (addr_low[1]) begin
        led_out[23:16] <= write_data[7:0];
      end else begin
        led_out[15:0]  <= write_data;
      end
    end
  end

  // Two-flop synchroniser followed by a stability counter: a new pattern must
  // sit unchanged on sync2 for DEBOUNCE_CYCLES cycles before it commits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      cnt       <= '0;
      sw_db     <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_db <= candidate;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Switch select takes priority should both chip selects ever be asserted.
  always_comb begin
    io_rdata = 16'h0000;
    if (ioRead && SwitchCtrl) begin
      io_rdata = addr_low[1] ? {8'h00, sw_db[23:16]} : sw_db[15:0];
    end else if (ioRead && LEDCtrl) begin
      io_rdata = addr_low[1] ? {8'h00, led_out[23:16]} : led_out[15:0];
    end
  end

endmodule
`default_nettype wire
